// File: rtl/ngram_temporal_encoder.sv
// Temporal N-gram encoder: binds the last NGRAM_SIZE spatial hypervectors by permute-and-XOR.
// Latency 1 cycle from the completing input transfer; input stalls only while a held output is unaccepted.
module ngram_temporal_encoder #(
  parameter int HV_DIMENSION = 2000,
  parameter int NGRAM_SIZE   = 3,
  parameter int MODE_WIDTH   = 2,
  parameter int LABEL_WIDTH  = 5
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RI,
  input  logic                     ValidIn_SI,
  output logic                     ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]    ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]   LabelIn_DI,
  input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
  output logic                     ValidOut_SO,
  input  logic                     ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]    ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]   LabelOut_DO,
  output logic [0:HV_DIMENSION-1]  HypervectorOut_DO
);

  localparam int FILL_WIDTH = $clog2(NGRAM_SIZE + 1);
  localparam logic [FILL_WIDTH-1:0] FILL_ONE  = FILL_WIDTH'(1);
  localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(NGRAM_SIZE);

  typedef enum logic [1:0] {EMPTY, FILLING, STREAMING} state_t;

  state_t                   stateQ, stateD;
  logic [FILL_WIDTH-1:0]    fillQ, fillD;
  logic [0:HV_DIMENSION-1]  histQ [NGRAM_SIZE];
  logic [0:HV_DIMENSION-1]  histD [NGRAM_SIZE];
  logic [MODE_WIDTH-1:0]    lastModeQ;
  logic [LABEL_WIDTH-1:0]   lastLabelQ;
  logic                     validQ;
  logic [MODE_WIDTH-1:0]    modeOutQ;
  logic [LABEL_WIDTH-1:0]   labelOutQ;
  logic [0:HV_DIMENSION-1]  hvOutQ;
  logic                     inXfer, outXfer, segBreak, emitNgram;
  logic [0:HV_DIMENSION-1]  ngram;

  // rho^k: bit i takes bit (i-k) mod D, i.e. a circular shift toward higher index
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x, input int k);
    logic [0:HV_DIMENSION-1] y;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      y[i] = x[(i + HV_DIMENSION - k) % HV_DIMENSION];
    end
    return y;
  endfunction

  assign ReadyOut_SO = ~validQ | ReadyIn_SI;
  assign inXfer      = ValidIn_SI & ReadyOut_SO;
  assign outXfer     = validQ & ReadyIn_SI;
  assign segBreak    = inXfer && (stateQ != EMPTY) &&
                       ((ModeIn_SI != lastModeQ) || (LabelIn_DI != lastLabelQ));

  always_comb begin
    stateD    = stateQ;
    fillD     = fillQ;
    emitNgram = 1'b0;
    case (stateQ)
      EMPTY:     if (inXfer) fillD = FILL_ONE;
      FILLING:   if (inXfer) fillD = segBreak ? FILL_ONE : fillQ + FILL_ONE;
      STREAMING: if (inXfer && segBreak) fillD = FILL_ONE;
      default:   fillD = '0;
    endcase
    if (inXfer) begin
      stateD    = (fillD == FILL_FULL) ? STREAMING : FILLING;
      emitNgram = (fillD == FILL_FULL);
    end
  end

  // Post-shift history; a segment break keeps only the new sample
  always_comb begin
    histD[0] = HypervectorIn_DI;
    for (int k = 1; k < NGRAM_SIZE; k++) begin
      histD[k] = segBreak ? '0 : histQ[k-1];
    end
    ngram = '0;
    for (int k = 0; k < NGRAM_SIZE; k++) begin
      ngram = ngram ^ rho(histD[k], k);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI) begin
      stateQ <= EMPTY;
      fillQ  <= '0;
    end else begin
      stateQ <= stateD;
      fillQ  <= fillD;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI) begin
      for (int k = 0; k < NGRAM_SIZE; k++) begin
        histQ[k] <= '0;
      end
      lastModeQ  <= '0;
      lastLabelQ <= '0;
      validQ     <= 1'b0;
      modeOutQ   <= '0;
      labelOutQ  <= '0;
      hvOutQ     <= '0;
    end else begin
      if (inXfer) begin
        for (int k = 0; k < NGRAM_SIZE; k++) begin
          histQ[k] <= histD[k];
        end
        lastModeQ  <= ModeIn_SI;
        lastLabelQ <= LabelIn_DI;
      end
      // A reload in the same cycle as an output transfer keeps the stream at full rate
      if (emitNgram) begin
        validQ    <= 1'b1;
        modeOutQ  <= ModeIn_SI;
        labelOutQ <= LabelIn_DI;
        hvOutQ    <= ngram;
      end else if (outXfer) begin
        validQ <= 1'b0;
      end
    end
  end

  assign ValidOut_SO       = validQ;
  assign ModeOut_SO        = modeOutQ;
  assign LabelOut_DO       = labelOutQ;
  assign HypervectorOut_DO = hvOutQ;

endmodule

// File: tb/tb_ngram_temporal_encoder.sv
// Bench for ngram_temporal_encoder: directed spec scenarios plus randomized traffic against a segment/queue model.
module tb_ngram_temporal_encoder;
  localparam int D  = 8;
  localparam int N  = 3;
  localparam int MW = 2;
  localparam int LW = 5;

  localparam logic [0:D-1] B0 = 8'b1000_0000;
  localparam logic [0:D-1] B3 = 8'b0001_0000;
  localparam logic [0:D-1] B6 = 8'b0000_0010;
  localparam logic [0:D-1] B7 = 8'b0000_0001;

  logic           Clk_CI = 1'b0;
  logic           Reset_RI;
  logic           ValidIn_SI;
  logic           ReadyOut_SO;
  logic [MW-1:0]  ModeIn_SI;
  logic [LW-1:0]  LabelIn_DI;
  logic [0:D-1]   HypervectorIn_DI;
  logic           ValidOut_SO;
  logic           ReadyIn_SI;
  logic [MW-1:0]  ModeOut_SO;
  logic [LW-1:0]  LabelOut_DO;
  logic [0:D-1]   HypervectorOut_DO;

  ngram_temporal_encoder #(
    .HV_DIMENSION(D), .NGRAM_SIZE(N), .MODE_WIDTH(MW), .LABEL_WIDTH(LW)
  ) dut (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
    .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
    .ModeIn_SI(ModeIn_SI), .LabelIn_DI(LabelIn_DI), .HypervectorIn_DI(HypervectorIn_DI),
    .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
    .ModeOut_SO(ModeOut_SO), .LabelOut_DO(LabelOut_DO), .HypervectorOut_DO(HypervectorOut_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int nChecks = 0;
  int nFails  = 0;
  int nOut    = 0;

  // Reference model: samples of the current segment (newest first) and pending outputs
  logic [0:D-1]  seg[$];
  logic [0:D-1]  expHv[$];
  logic [MW-1:0] expMd[$];
  logic [LW-1:0] expLb[$];
  logic          started = 1'b0;
  logic [MW-1:0] lastMd = '0;
  logic [LW-1:0] lastLb = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Each set bit j of the k-th newest sample lands on bit (j+k) mod D
  function automatic logic [0:D-1] modelNgram();
    logic [0:D-1] r;
    r = '0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < D; j++)
        if (seg[k][j]) r[(j + k) % D] = ~r[(j + k) % D];
    return r;
  endfunction

  // Called at a falling edge: drive inputs, check outputs, advance the model, move to the next falling edge
  task automatic step(input logic rst, input logic vin, input logic [0:D-1] hv,
                      input logic [MW-1:0] md, input logic [LW-1:0] lb, input logic rin);
    logic expValid;
    logic accepted;
    Reset_RI = rst; ValidIn_SI = vin; HypervectorIn_DI = hv;
    ModeIn_SI = md; LabelIn_DI = lb; ReadyIn_SI = rin;
    #1;
    expValid = (expHv.size() != 0);
    chk("valid", 64'(ValidOut_SO), 64'(expValid));
    chk("ready", 64'(ReadyOut_SO), 64'(!expValid || rin));
    if (expValid) begin
      chk("out_hv", 64'(HypervectorOut_DO), 64'(expHv[0]));
      chk("out_mode", 64'(ModeOut_SO), 64'(expMd[0]));
      chk("out_label", 64'(LabelOut_DO), 64'(expLb[0]));
    end
    accepted = vin && (!expValid || rin);
    if (!rst) begin
      seg.delete(); expHv.delete(); expMd.delete(); expLb.delete();
      started = 1'b0;
    end else begin
      if (expValid && rin) begin
        void'(expHv.pop_front()); void'(expMd.pop_front()); void'(expLb.pop_front());
        nOut++;
      end
      if (accepted) begin
        if (started && (md != lastMd || lb != lastLb)) seg.delete();
        seg.push_front(hv);
        if (seg.size() > N) void'(seg.pop_back());
        started = 1'b1; lastMd = md; lastLb = lb;
        if (seg.size() == N) begin
          expHv.push_back(modelNgram()); expMd.push_back(md); expLb.push_back(lb);
        end
      end
    end
    @(posedge Clk_CI);
    @(negedge Clk_CI);
  endtask

  initial begin
    logic [MW-1:0] curMd;
    logic [LW-1:0] curLb;
    int outBefore;
    Reset_RI = 1'b0; ValidIn_SI = 1'b0; HypervectorIn_DI = '0;
    ModeIn_SI = '0; LabelIn_DI = '0; ReadyIn_SI = 1'b0;
    @(posedge Clk_CI);
    @(negedge Clk_CI);

    // Reset with a sample presented: dropped, outputs zero
    step(1'b0, 1'b1, B0, 2'd1, 5'd4, 1'b1);
    chk("rst_valid", 64'(ValidOut_SO), 64'(0));
    chk("rst_hv", 64'(HypervectorOut_DO), 64'(0));
    chk("rst_mode", 64'(ModeOut_SO), 64'(0));
    chk("rst_label", 64'(LabelOut_DO), 64'(0));

    // Three identical samples give exactly one N-gram
    outBefore = nOut;
    step(1'b1, 1'b1, B0, 2'd1, 5'd4, 1'b1);
    chk("t2_noout1", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd1, 5'd4, 1'b1);
    chk("t2_noout2", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd1, 5'd4, 1'b1);
    chk("t2_valid", 64'(ValidOut_SO), 64'(1));
    chk("t2_hv", 64'(HypervectorOut_DO), 64'(8'b1110_0000));
    chk("t2_mode", 64'(ModeOut_SO), 64'(1));
    chk("t2_label", 64'(LabelOut_DO), 64'(4));
    step(1'b1, 1'b0, '0, 2'd1, 5'd4, 1'b1);
    chk("t2_count", 64'(nOut - outBefore), 64'(1));
    chk("t2_drained", 64'(ValidOut_SO), 64'(0));

    // Wrap-around of the top bit
    step(1'b1, 1'b1, B7, 2'd1, 5'd4, 1'b1);
    step(1'b1, 1'b1, B7, 2'd1, 5'd4, 1'b1);
    step(1'b1, 1'b1, B6, 2'd1, 5'd4, 1'b1);
    chk("t3_hv", 64'(HypervectorOut_DO), 64'(8'b1100_0010));
    step(1'b1, 1'b0, '0, 2'd1, 5'd4, 1'b1);

    // Label change splits segments
    step(1'b1, 1'b1, B0, 2'd1, 5'd2, 1'b1);
    chk("t4_l2a", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd1, 5'd2, 1'b1);
    chk("t4_l2b", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B3, 2'd1, 5'd5, 1'b1);
    chk("t4_l5a", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B3, 2'd1, 5'd5, 1'b1);
    chk("t4_l5b", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B3, 2'd1, 5'd5, 1'b1);
    chk("t4_hv", 64'(HypervectorOut_DO), 64'(8'b0001_1100));
    chk("t4_label", 64'(LabelOut_DO), 64'(5));

    // Backpressure: held output, fourth sample refused until ReadyIn rises
    step(1'b1, 1'b1, B0, 2'd1, 5'd5, 1'b0);
    step(1'b1, 1'b1, B0, 2'd1, 5'd5, 1'b0);
    chk("t5_ready", 64'(ReadyOut_SO), 64'(0));
    chk("t5_hold", 64'(HypervectorOut_DO), 64'(8'b0001_1100));
    outBefore = nOut;
    step(1'b1, 1'b1, B0, 2'd1, 5'd5, 1'b1);
    chk("t5_xfer", 64'(nOut - outBefore), 64'(1));
    chk("t5_valid", 64'(ValidOut_SO), 64'(1));
    chk("t5_hv", 64'(HypervectorOut_DO), 64'(8'b1000_1100));

    // Reset discards a held output and clears the fill
    step(1'b0, 1'b0, '0, 2'd0, 5'd0, 1'b0);
    chk("t6_valid", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd0, 5'd1, 1'b1);
    chk("t6_noout1", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd0, 5'd1, 1'b1);
    chk("t6_noout2", 64'(ValidOut_SO), 64'(0));
    step(1'b1, 1'b1, B0, 2'd0, 5'd1, 1'b1);
    chk("t6_valid3", 64'(ValidOut_SO), 64'(1));
    chk("t6_hv", 64'(HypervectorOut_DO), 64'(8'b1110_0000));

    // Randomized traffic against the model
    curMd = 2'd0; curLb = 5'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) curLb = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) curMd = 2'($urandom_range(0, 1));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), 8'($urandom),
           curMd, curLb, ($urandom_range(0, 9) < 7));
    end
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, curMd, curLb, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
